instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 86 ++++++++
 tb/tb_instr_fetch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register plus a FETCH/WAIT/DROP FSM that keeps at most one
// imem request in flight and pushes {pc, instr} into the instruction buffer.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        buf_full,
   output logic        buf_write_en,
   output logic [63:0] buf_write_data,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_DROP  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_pc;

   logic        w_handshake;
   logic [31:0] w_redirect_pc;
   logic        w_unused_ok;

   // Handshake: a request transfers on a rising edge where imem_req_valid && imem_req_ready;
   // valid is only raised in FETCH, so no second request can start before the response.
   assign imem_req_valid = reset && (r_state == S_FETCH) && !buf_full && !redirect_valid;
   assign w_handshake    = imem_req_valid && imem_req_ready;
   assign imem_req_addr  = r_pc;

   assign buf_write_en   = reset && (r_state == S_WAIT) && imem_resp_valid && !redirect_valid;
   assign buf_write_data = {r_req_pc, imem_resp_data};

   assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};
   assign w_unused_ok    = &{1'b0, redirect_pc[1:0]};
   assign o_dbg_state    = r_state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_FETCH;
         r_pc     <= RESET_PC;
         r_req_pc <= RESET_PC;
      end else if (redirect_valid) begin
         // Redirect wins over everything; an in-flight response must still be drained.
         r_pc <= w_redirect_pc;
         case (r_state)
            S_FETCH: r_state <= S_FETCH;
            S_WAIT:  r_state <= imem_resp_valid ? S_FETCH : S_DROP;
            S_DROP:  r_state <= S_DROP;
            default: r_state <= S_FETCH;
         endcase
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_handshake) begin
                  r_req_pc <= r_pc;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  r_pc    <= r_req_pc + 32'd4;
                  r_state <= S_FETCH;
               end
            end
            S_DROP: begin
               if (imem_resp_valid) begin
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-by-cycle vector table plus hand-written
// sequences for backpressure and reset during an outstanding request.
module tb_instr_fetch;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_DROP  = 2'd2;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        buf_full;
   logic        buf_write_en;
   logic [63:0] buf_write_data;
   logic [1:0]  o_dbg_state;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        rdv;
      logic [31:0] rpc;
      logic        full;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_wen;
      logic [63:0] e_wdata;
      logic [1:0]  e_state;
   } vec_t;

   vec_t vecs[$];

   instr_fetch dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .buf_full        (buf_full),
      .buf_write_en    (buf_write_en),
      .buf_write_data  (buf_write_data),
      .o_dbg_state     (o_dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rdata,
                        input logic rdv, input logic [31:0] rpc, input logic full);
      @(negedge clk);
      reset           = rst;
      imem_req_ready  = rdy;
      imem_resp_valid = rv;
      imem_resp_data  = rdata;
      redirect_valid  = rdv;
      redirect_pc     = rpc;
      buf_full        = full;
      #1;
   endtask

   task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_wen, input logic [63:0] e_wdata, input logic [1:0] e_state);
      chk({tag, ".req_valid"}, {63'd0, imem_req_valid}, {63'd0, e_req});
      chk({tag, ".req_addr"}, {32'd0, imem_req_addr}, {32'd0, e_addr});
      chk({tag, ".wr_en"}, {63'd0, buf_write_en}, {63'd0, e_wen});
      if (e_wen) chk({tag, ".wr_data"}, buf_write_data, e_wdata);
      chk({tag, ".state"}, {62'd0, o_dbg_state}, {62'd0, e_state});
   endtask

   task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rdata,
                      input logic rdv, input logic [31:0] rpc, input logic full,
                      input logic e_req, input logic [31:0] e_addr, input logic e_wen,
                      input logic [63:0] e_wdata, input logic [1:0] e_state);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.rdv = rdv; v.rpc = rpc;
      v.full = full; v.e_req = e_req; v.e_addr = e_addr; v.e_wen = e_wen;
      v.e_wdata = e_wdata; v.e_state = e_state;
      vecs.push_back(v);
   endtask

   initial begin
      reset = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; buf_full = 1'b0;
      repeat (2) @(posedge clk);

      //   rst rdy rv rdata          rdv rpc            full | req addr          wen wdata                   state
      // reset held, then sequential fetch with 2-cycle response latency
      add(0, 1, 0, 32'h0,          0, 32'h0,          0,   0, 32'h0,          0, 64'h0,                   ST_FETCH);
      add(1, 1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0,          0, 64'h0,                   ST_FETCH);
      add(1, 0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h0,          0, 64'h0,                   ST_WAIT);
      add(1, 0, 1, 32'h00000013,   0, 32'h0,          0,   0, 32'h0,          1, 64'h00000000_00000013,   ST_WAIT);
      add(1, 1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h4,          0, 64'h0,                   ST_FETCH);
      add(1, 0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h4,          0, 64'h0,                   ST_WAIT);
      add(1, 0, 1, 32'h00100093,   0, 32'h0,          0,   0, 32'h4,          1, 64'h00000004_00100093,   ST_WAIT);
      add(1, 0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h8,          0, 64'h0,                   ST_FETCH);
      // response while in FETCH is ignored
      add(1, 0, 1, 32'hBAD0BAD0,   0, 32'h0,          0,   1, 32'h8,          0, 64'h0,                   ST_FETCH);
      // redirect in FETCH suppresses request, then redirect while waiting -> DROP
      add(1, 1, 0, 32'h0,          1, 32'h10,         0,   0, 32'h8,          0, 64'h0,                   ST_FETCH);
      add(1, 1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h10,         0, 64'h0,                   ST_FETCH);
      add(1, 0, 0, 32'h0,          1, 32'h203,        0,   0, 32'h10,         0, 64'h0,                   ST_WAIT);
      add(1, 0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h200,        0, 64'h0,                   ST_DROP);
      add(1, 0, 0, 32'h0,          0, 32'h0,          0,   0, 32'h200,        0, 64'h0,                   ST_DROP);
      add(1, 0, 1, 32'h12345678,   0, 32'h0,          0,   0, 32'h200,        0, 64'h0,                   ST_DROP);
      add(1, 1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h200,        0, 64'h0,                   ST_FETCH);
      // redirect coincident with response
      add(1, 0, 1, 32'h87654321,   1, 32'h400,        0,   0, 32'h200,        0, 64'h0,                   ST_WAIT);
      add(1, 0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h400,        0, 64'h0,                   ST_FETCH);
      // back-to-back redirects, last one wins
      add(1, 1, 0, 32'h0,          1, 32'h100,        0,   0, 32'h400,        0, 64'h0,                   ST_FETCH);
      add(1, 1, 0, 32'h0,          1, 32'h104,        0,   0, 32'h100,        0, 64'h0,                   ST_FETCH);
      add(1, 0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h104,        0, 64'h0,                   ST_FETCH);
      // redirect while in DROP stays in DROP
      add(1, 1, 0, 32'h0,          0, 32'h0,          0,   1, 32'h104,        0, 64'h0,                   ST_FETCH);
      add(1, 0, 0, 32'h0,          1, 32'h300,        0,   0, 32'h104,        0, 64'h0,                   ST_WAIT);
      add(1, 0, 0, 32'h0,          1, 32'h502,        0,   0, 32'h300,        0, 64'h0,                   ST_DROP);
      add(1, 0, 1, 32'h11111111,   0, 32'h0,          0,   0, 32'h500,        0, 64'h0,                   ST_DROP);
      add(1, 0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h500,        0, 64'h0,                   ST_FETCH);
      // PC wrap; low redirect bits ignored
      add(1, 1, 0, 32'h0,          1, 32'hFFFFFFFF,   0,   0, 32'h500,        0, 64'h0,                   ST_FETCH);
      add(1, 1, 0, 32'h0,          0, 32'h0,          0,   1, 32'hFFFFFFFC,   0, 64'h0,                   ST_FETCH);
      add(1, 0, 1, 32'hDEADBEEF,   0, 32'h0,          0,   0, 32'hFFFFFFFC,   1, 64'hFFFFFFFC_DEADBEEF,   ST_WAIT);
      add(1, 0, 0, 32'h0,          0, 32'h0,          0,   1, 32'h0,          0, 64'h0,                   ST_FETCH);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].rdv, vecs[i].rpc, vecs[i].full);
         check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_wen,
                    vecs[i].e_wdata, vecs[i].e_state);
      end

      // backpressure: buf_full for 5 cycles in FETCH at pc 0, request issues as it falls
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0, 32'h0, 0, 32'h0, 1);
         check_outs($sformatf("bp%0d", i), 0, 32'h0, 0, 64'h0, ST_FETCH);
      end
      drive(1, 1, 0, 32'h0, 0, 32'h0, 0);
      check_outs("bp_release", 1, 32'h0, 0, 64'h0, ST_FETCH);
      drive(1, 0, 1, 32'hA5A5A5A5, 0, 32'h0, 0);
      check_outs("bp_push", 0, 32'h0, 1, 64'h00000000_A5A5A5A5, ST_WAIT);

      // reset pulse while waiting; stale response right after release is ignored
      drive(1, 1, 0, 32'h0, 0, 32'h0, 0);
      check_outs("rst_req", 1, 32'h4, 0, 64'h0, ST_FETCH);
      drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
      check_outs("rst_pulse", 0, 32'h4, 0, 64'h0, ST_WAIT);
      drive(1, 1, 1, 32'h5A5A5A5A, 0, 32'h0, 0);
      check_outs("rst_stale", 1, 32'h0, 0, 64'h0, ST_FETCH);
      drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
      check_outs("rst_wait", 0, 32'h0, 0, 64'h0, ST_WAIT);
      drive(1, 0, 1, 32'h00000093, 0, 32'h0, 0);
      check_outs("rst_push", 0, 32'h0, 1, 64'h00000000_00000093, ST_WAIT);
      drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
      check_outs("rst_next", 1, 32'h4, 0, 64'h0, ST_FETCH);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
